// File: rtl/key_expand_ctrl.sv
// rtl/key_expand_ctrl.sv - AES-128 key schedule controller, one round key per cycle
//
// Purpose: expands a 128-bit AES key into rk[0..10], one round per clock,
// using a single G-function (four S-box lookups) shared by all rounds.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       request expansion of key_in (only honoured in IDLE)
//   abort       synchronous cancel, returns to IDLE, beats start
//   key_in      cipher key, w0 = key_in[127:96]
//   busy        high while expanding
//   done        one-cycle pulse once rk[10] is stored
//   rk_valid    store holds a complete schedule
//   rk_rd_addr  round-key read index
//   rk_rd_data  round key at rk_rd_addr (0 for indices 11..15)

module key_expand_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         rk_valid,
  input  logic [3:0]   rk_rd_addr,
  output logic [127:0] rk_rd_data
);

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } state_t;

  // FIPS-197 S-box, row-major; byte i sits at bits [2047-8*i -: 8].
  localparam logic [2047:0] SBOX_ROM = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    int idx;
    idx = 2047 - 8 * int'(b);
    return SBOX_ROM[idx -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  state_t       state;
  logic [3:0]   round;
  logic [127:0] rk [11];

  logic [127:0] prev_rk;
  logic [31:0]  rot_w;
  logic [31:0]  t_w;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] next_rk;

  // Previous round key; round is 1..10 whenever this result is consumed.
  always_comb begin
    prev_rk = '0;
    for (int i = 0; i < 10; i++) begin
      if (round == 4'(i + 1)) begin
        prev_rk = rk[i];
      end
    end
  end

  // The single G-function plus the word XOR chain.
  always_comb begin
    rot_w   = {prev_rk[23:0], prev_rk[31:24]};
    t_w     = {sub_byte(rot_w[31:24]), sub_byte(rot_w[23:16]),
               sub_byte(rot_w[15:8]),  sub_byte(rot_w[7:0])}
              ^ {rcon(round), 24'h0};
    n0      = prev_rk[127:96] ^ t_w;
    n1      = prev_rk[95:64]  ^ n0;
    n2      = prev_rk[63:32]  ^ n1;
    n3      = prev_rk[31:0]   ^ n2;
    next_rk = {n0, n1, n2, n3};
  end

  always_comb begin
    rk_rd_data = '0;
    for (int i = 0; i < 11; i++) begin
      if (rk_rd_addr == 4'(i)) begin
        rk_rd_data = rk[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      round    <= 4'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rk_valid <= 1'b0;
      for (int i = 0; i < 11; i++) begin
        rk[i] <= '0;
      end
    end else if (abort) begin
      // Store contents are left as-is; rk_valid marks them unusable.
      state    <= IDLE;
      round    <= 4'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rk_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            rk[0]    <= key_in;
            round    <= 4'd1;
            rk_valid <= 1'b0;
            busy     <= 1'b1;
            state    <= EXPAND;
          end
        end
        EXPAND: begin
          for (int i = 1; i < 11; i++) begin
            if (round == 4'(i)) begin
              rk[i] <= next_rk;
            end
          end
          if (round == 4'd10) begin
            // Hold at 10 so the counter never passes the last round.
            busy     <= 1'b0;
            done     <= 1'b1;
            rk_valid <= 1'b1;
            state    <= DONE;
          end else begin
            round <= round + 4'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_expand_ctrl.sv
// tb/tb_key_expand_ctrl.sv - scoreboard bench for key_expand_ctrl
`timescale 1ns/1ps

module tb_key_expand_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic [127:0] key_in;
  logic         busy;
  logic         done;
  logic         rk_valid;
  logic [3:0]   rk_rd_addr;
  logic [127:0] rk_rd_data;

  key_expand_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .key_in     (key_in),
    .busy       (busy),
    .done       (done),
    .rk_valid   (rk_valid),
    .rk_rd_addr (rk_rd_addr),
    .rk_rd_data (rk_rd_data)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [127:0] key;
    int           due;
  } exp_t;
  exp_t sb_q[$];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic [7:0] sbox_tbl [256];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      end
      sbox_tbl[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                    ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Word-oriented FIPS-197 KeyExpansion; returns round key r.
  function automatic logic [127:0] ref_rk(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_tbl[tmp[31:24]], sbox_tbl[tmp[23:16]],
               sbox_tbl[tmp[15:8]], sbox_tbl[tmp[7:0]]};
        tmp[31:24] = tmp[31:24] ^ rc;
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic rd(input logic [3:0] a, output logic [127:0] d);
    rk_rd_addr = a;
    #0.5;
    d = rk_rd_data;
  endtask

  // Monitor: every done pulse must match the head of the scoreboard.
  initial begin
    logic [127:0] d;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        if (sb_q.size() == 0) begin
          checks++;
          $display("FAIL spurious_done: done=1 with no expansion pending (cyc=%0d)", cyc);
        end else begin
          e = sb_q.pop_front();
          chk("done_cycle", 128'(cyc), 128'(e.due));
          chk("busy_at_done", 128'(busy), 128'd0);
          chk("valid_at_done", 128'(rk_valid), 128'd1);
          for (int r = 0; r < 11; r++) begin
            rd(4'(r), d);
            chk($sformatf("rk[%0d]", r), d, ref_rk(e.key, r));
          end
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Launch one expansion; the accepting edge is the next rising edge.
  task automatic start_exp(input logic [127:0] key, input bit expect_done);
    exp_t e;
    @(posedge clk); #1;
    key_in = key;
    start  = 1'b1;
    if (expect_done) begin
      e.key = key;
      e.due = cyc + 11;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (sb_q.size() == 0 && !busy && !done) break;
      @(posedge clk);
    end
    #1;
    chk("expansion_completes", 128'(sb_q.size()), 128'd0);
  endtask

  task automatic check_all_zero(input string tag);
    logic [127:0] d;
    chk({tag, "_busy"}, 128'(busy), 128'd0);
    chk({tag, "_done"}, 128'(done), 128'd0);
    chk({tag, "_valid"}, 128'(rk_valid), 128'd0);
    for (int a = 0; a < 16; a++) begin
      rd(4'(a), d);
      chk($sformatf("%s_rd%0d", tag, a), d, 128'h0);
    end
  endtask

  initial begin
    logic [127:0] d;
    exp_t e;
    int e0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; key_in = '0; rk_rd_addr = '0;
    build_sbox();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // FIPS-197 vector with busy window check.
    start_exp(FIPS_KEY, 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("busy_E%0d", k), 128'(busy), 128'd1);
    end
    @(negedge clk);
    chk("busy_low_E10", 128'(busy), 128'd0);
    wait_idle();
    rd(4'd1, d);  chk("fips_rk1", d, 128'ha0fafe1788542cb123a339392a6c7605);
    rd(4'd10, d); chk("fips_rk10", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("fips_valid", 128'(rk_valid), 128'd1);
    for (int a = 11; a < 16; a++) begin
      rd(4'(a), d);
      chk($sformatf("rd_oob%0d", a), d, 128'h0);
    end

    // All-zero key.
    start_exp(128'h0, 1'b1);
    wait_idle();
    rd(4'd1, d);  chk("zero_rk1", d, 128'h62636363626363636263636362636363);
    rd(4'd10, d); chk("zero_rk10", d, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    chk("zero_valid", 128'(rk_valid), 128'd1);

    // Re-pulsed start at E3 and key_in changes after acceptance are ignored.
    start_exp(FIPS_KEY, 1'b1);
    key_in = {$urandom, $urandom, $urandom, $urandom};
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
    rd(4'd10, d); chk("repulse_rk10", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    repeat (3) @(posedge clk);
    #1;
    chk("repulse_not_queued", 128'(busy), 128'd0);

    // Abort at E5: sampled at E6, no done.
    start_exp({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("abort_busy_before", 128'(busy), 128'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_valid", 128'(rk_valid), 128'd0);
    repeat (15) @(posedge clk);
    start_exp({$urandom, $urandom, $urandom, $urandom}, 1'b1);
    wait_idle();

    // Reset mid-expansion, then silence.
    start_exp({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (15) @(posedge clk);

    // Start held across reset release is taken at the first edge.
    @(posedge clk); #1;
    rst_n = 1'b0;
    start = 1'b1;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    rst_n = 1'b1;
    e.key = key_in; e.due = cyc + 11;
    sb_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();

    // Back-to-back with start held: done pulses 12 cycles apart.
    @(posedge clk); #1;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    start = 1'b1;
    e.key = key_in; e.due = cyc + 11;
    sb_q.push_back(e);
    @(posedge clk); #1;
    e0 = cyc;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    e.key = key_in; e.due = e0 + 22;
    sb_q.push_back(e);
    repeat (12) @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();

    // Random keys with random gaps.
    for (int n = 0; n < 12; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      start_exp({$urandom, $urandom, $urandom, $urandom}, 1'b1);
      wait_idle();
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/key_expand_ctrl.md
KEY_EXPAND_CTRL -- requirements
Module: key_expand_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The ports SHALL be as follows, one per line, clock and reset first:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request expansion of key_in; sampled only in IDLE
- abort  input  1  synchronous cancel; returns to IDLE
- key_in  input  128  AES-128 cipher key; w0 = key_in[127:96], w3 = key_in[31:0]
- busy  output  1  high while in EXPAND
- done  output  1  one-cycle pulse when all round keys are stored
- rk_valid  output  1  round-key store holds a complete schedule
- rk_rd_addr  input  4  round-key read index, 0..10
- rk_rd_data  output  128  round key at rk_rd_addr, combinational read

Function
REQ-003 The FSM SHALL have three states: IDLE, EXPAND and DONE.
REQ-004 In IDLE, a rising edge with start=1 and abort=0 SHALL write rk[0] <= key_in, set round <= 1, clear rk_valid and enter EXPAND.
REQ-005 In EXPAND, each rising edge SHALL write rk[round] from rk[round-1] and increment round.
REQ-006 The edge that writes rk[10] SHALL move the FSM to DONE.
REQ-007 In DONE, done SHALL be 1 and rk_valid SHALL be set; the next edge SHALL return the FSM to IDLE.
REQ-008 Latency: when start is accepted at edge E0, rk[10] SHALL be written at E10 and done SHALL be high for exactly the cycle between E10 and E11.
REQ-009 busy SHALL be 1 only in EXPAND; done SHALL be 1 only in DONE.
REQ-010 Round-key derivation, with p = rk[round-1] split into words p0..p3 (p0 = MSBs):
- t = SubWord(RotWord(p3)) XOR {rcon[round], 24'h0}
- RotWord(w) = {w[23:0], w[31:24]}
- SubWord applies the FIPS-197 S-box to each byte
- n0 = p0^t, n1 = p1^n0, n2 = p2^n1, n3 = p3^n2
- rk[round] = {n0, n1, n2, n3}
REQ-011 rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1B,36 (hex); round 0 and rounds 11..15 are never applied.
REQ-012 Exactly one G-function evaluation (4 S-box lookups) SHALL be performed per cycle; the block SHALL not unroll rounds.
REQ-013 start asserted in EXPAND or DONE SHALL be ignored and not queued.
REQ-014 abort=1 in any state SHALL, at the next edge, force the FSM to IDLE and clear rk_valid and round. Stored rk contents need not be cleared. abort SHALL have priority over start.
REQ-015 rk_rd_data SHALL return rk[rk_rd_addr] combinationally for addresses 0..10 and 128'h0 for 11..15.
REQ-016 Reads during EXPAND SHALL return the current store contents: already-written rounds are new, the rest are stale.
REQ-017 key_in SHALL only be sampled at the accepting edge; later changes SHALL not affect the schedule in progress.
REQ-018 round SHALL be a 4-bit counter that never exceeds 10 and never wraps.

Reset
REQ-019 When rst_n=0, the block SHALL asynchronously force: FSM=IDLE, round=0, busy=0, done=0, rk_valid=0, and all rk[0..10]=128'h0.
REQ-020 Reset asserted mid-expansion SHALL discard the expansion. After deassertion, no done pulse SHALL occur without a new start.
REQ-021 A start held high across reset deassertion SHALL be accepted at the first rising edge after deassertion.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- FIPS-197 vector: key 2b7e151628aed2a6abf7158809cf4f3c, start at E0 -> rk[1]=a0fafe1788542cb123a339392a6c7605, rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6, done high only between E10 and E11, busy high E0..E10.
- All-zero key -> rk[1]=62636363626363636263636362636363, rk[10]=b4ef5bcb3e92e21123e951cf6f8f188e, rk_valid=1 after done.
- start re-pulsed at E3 with a different key_in -> ignored; results identical to the first scenario.
- abort at E5 -> IDLE at E6, rk_valid=0, no done; a fresh start then completes normally.
- rst_n low at E4 -> all outputs 0 immediately, rk_rd_data=0 for all addresses; no done after release.
- rk_rd_addr=11..15 -> rk_rd_data=0. Back-to-back starts (start held high) -> second expansion accepted the cycle after DONE; done pulses 12 cycles apart.
